// File: rtl/alu_pkg.sv
// Shared definitions for the ALU scheduler: ALU select codes, the ALU's
// default result for reserved selects, and the scheduler FSM state encoding.
package alu_pkg;

    localparam logic [3:0] ALU_OP_ZERO   = 4'h0;
    localparam logic [3:0] ALU_OP_PASS_A = 4'h1;
    localparam logic [3:0] ALU_OP_PASS_B = 4'h2;
    localparam logic [3:0] ALU_OP_AND    = 4'h3;
    localparam logic [3:0] ALU_OP_OR     = 4'h4;
    localparam logic [3:0] ALU_OP_ROL_A  = 4'h5;
    localparam logic [3:0] ALU_OP_ROR_A  = 4'h6;
    localparam logic [3:0] ALU_OP_XOR    = 4'h7;
    localparam logic [3:0] ALU_OP_SHL_A  = 4'h8;
    localparam logic [3:0] ALU_OP_NOT_A  = 4'h9;
    localparam logic [3:0] ALU_OP_INC_A  = 4'hA;
    localparam logic [3:0] ALU_OP_SUB    = 4'hB;
    localparam logic [3:0] ALU_OP_ADD    = 4'hC;
    localparam logic [3:0] ALU_OP_RSVD_D = 4'hD;
    localparam logic [3:0] ALU_OP_RSVD_E = 4'hE;
    localparam logic [3:0] ALU_OP_ONES   = 4'hF;

    // Value the ALU returns for the two reserved select codes.
    localparam logic [7:0] ALU_DEFAULT_RESULT = 8'h81;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    function automatic logic is_illegal_op(input logic [3:0] op);
        return (op == ALU_OP_RSVD_D) || (op == ALU_OP_RSVD_E);
    endfunction

endpackage

// File: rtl/rr_arbiter2.sv
// Two-way round-robin arbiter: one-hot grant; on a tie the requester that
// did not win last time is chosen.
module rr_arbiter2 (
    input  logic [1:0] req,
    input  logic       last,
    output logic [1:0] grant
);

    assign grant[0] = req[0] & (~req[1] | last);
    assign grant[1] = req[1] & (~req[0] | ~last);

endmodule

// File: rtl/alu_scheduler.sv
// Shares one combinational ALU between two requesters: round-robin accept,
// registered ALU drive, result capture and valid/ready response.
// Optional reserved-opcode trapping is enabled with `define ALU_SCHED_OPCHECK_EN.
module alu_scheduler
    import alu_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [1:0]       req_valid,
    output logic [1:0]       req_ready,
    input  logic [3:0]       req0_op,
    input  logic [WIDTH-1:0] req0_a,
    input  logic [WIDTH-1:0] req0_b,
    input  logic [3:0]       req1_op,
    input  logic [WIDTH-1:0] req1_a,
    input  logic [WIDTH-1:0] req1_b,
    output logic [3:0]       alu_sel,
    output logic [WIDTH-1:0] alu_a,
    output logic [WIDTH-1:0] alu_b,
    input  logic [WIDTH-1:0] alu_x,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic             rsp_id,
    output logic [WIDTH-1:0] rsp_data,
    output logic             rsp_err,
    output logic             busy,
    output logic [CNT_W-1:0] op_count
);

    state_t           state, state_next;
    logic             last_grant;
    logic [1:0]       grant;
    logic             accept;
    logic             winner;
    logic             win_illegal;
    logic [3:0]       win_op;
    logic [WIDTH-1:0] win_a, win_b;

    rr_arbiter2 u_arb (
        .req   (req_valid),
        .last  (last_grant),
        .grant (grant)
    );

    assign req_ready = (state == ST_IDLE) ? grant : 2'b00;
    assign accept    = |req_ready;
    assign winner    = grant[1];
    assign win_op    = winner ? req1_op : req0_op;
    assign win_a     = winner ? req1_a  : req0_a;
    assign win_b     = winner ? req1_b  : req0_b;
    assign busy      = (state != ST_IDLE);

`ifdef ALU_SCHED_OPCHECK_EN
    // Reserved selects are answered directly from IDLE without touching the ALU.
    assign win_illegal = is_illegal_op(win_op);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rsp_err <= 1'b0;
        end else if (state == ST_IDLE && accept) begin
            rsp_err <= win_illegal;
        end else if (state == ST_RESP && rsp_ready) begin
            rsp_err <= 1'b0;
        end
    end
`else
    assign win_illegal = 1'b0;
    assign rsp_err     = 1'b0;
`endif

    always_comb begin
        // NOTE: default first, so every path assigns state_next and no latch is inferred.
        state_next = state;
        case (state)
            ST_IDLE: if (accept) state_next = win_illegal ? ST_RESP : ST_EXEC;
            ST_EXEC: state_next = ST_RESP;
            ST_RESP: if (rsp_ready) state_next = ST_IDLE;
            default: state_next = ST_IDLE;
        endcase
    end

    // NOTE: non-blocking assignments keep every register sampling pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= ST_IDLE;
            last_grant <= 1'b1;
            alu_sel    <= '0;
            alu_a      <= '0;
            alu_b      <= '0;
            rsp_valid  <= 1'b0;
            rsp_id     <= 1'b0;
            rsp_data   <= '0;
            op_count   <= '0;
        end else begin
            state <= state_next;
            case (state)
                ST_IDLE: begin
                    if (accept) begin
                        rsp_id     <= winner;
                        last_grant <= winner;
                        if (win_illegal) begin
                            rsp_valid <= 1'b1;
                            rsp_data  <= '0;
                        end else begin
                            alu_sel <= win_op;
                            alu_a   <= win_a;
                            alu_b   <= win_b;
                        end
                    end
                end
                ST_EXEC: begin
                    rsp_data  <= alu_x;
                    rsp_valid <= 1'b1;
                end
                ST_RESP: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        op_count  <= op_count + CNT_W'(1);
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_scheduler.sv
// Self-checking bench for alu_scheduler: directed scenarios plus randomized
// transactions checked against a transaction-level reference model.
module tb_alu_scheduler;
    import alu_pkg::*;

`ifdef ALU_SCHED_OPCHECK_EN
    localparam bit OPCHECK = 1'b1;
`else
    localparam bit OPCHECK = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n;
    logic [1:0]  req_valid, req_ready;
    logic [3:0]  req0_op, req1_op;
    logic [7:0]  req0_a, req0_b, req1_a, req1_b;
    logic [3:0]  alu_sel;
    logic [7:0]  alu_a, alu_b, alu_x;
    logic        rsp_valid, rsp_ready, rsp_id, rsp_err, busy;
    logic [7:0]  rsp_data;
    logic [15:0] op_count;

    int checks   = 0;
    int failures = 0;

    // Reference model state (transaction level).
    logic        m_last;
    logic [3:0]  m_sel;
    logic [7:0]  m_a, m_b;
    logic [15:0] m_count;

    always #5 clk = ~clk;

    alu_scheduler #(.WIDTH(8), .CNT_W(16)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready),
        .req0_op(req0_op), .req0_a(req0_a), .req0_b(req0_b),
        .req1_op(req1_op), .req1_a(req1_a), .req1_b(req1_b),
        .alu_sel(alu_sel), .alu_a(alu_a), .alu_b(alu_b), .alu_x(alu_x),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
        .rsp_data(rsp_data), .rsp_err(rsp_err), .busy(busy), .op_count(op_count)
    );

    function automatic logic [7:0] alu_ref(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b);
        case (op)
            ALU_OP_ZERO:   return 8'h00;
            ALU_OP_PASS_A: return a;
            ALU_OP_PASS_B: return b;
            ALU_OP_AND:    return a & b;
            ALU_OP_OR:     return a | b;
            ALU_OP_ROL_A:  return {a[6:0], a[7]};
            ALU_OP_ROR_A:  return {a[0], a[7:1]};
            ALU_OP_XOR:    return a ^ b;
            ALU_OP_SHL_A:  return a << 1;
            ALU_OP_NOT_A:  return ~a;
            ALU_OP_INC_A:  return a + 8'd1;
            ALU_OP_SUB:    return a - b;
            ALU_OP_ADD:    return a + b;
            ALU_OP_ONES:   return 8'hFF;
            default:       return 8'h81;
        endcase
    endfunction

    // Combinational ALU model sitting behind the scheduler.
    assign alu_x = alu_ref(alu_sel, alu_a, alu_b);

    task automatic model_reset();
        m_last  = 1'b1;
        m_sel   = '0;
        m_a     = '0;
        m_b     = '0;
        m_count = '0;
    endtask

    // One full transaction from an IDLE cycle, entered ~1 time unit after a rising edge.
    task automatic run_txn(input logic [1:0] v,
                           input logic [3:0] op0, input logic [7:0] a0, input logic [7:0] b0,
                           input logic [3:0] op1, input logic [7:0] a1, input logic [7:0] b1,
                           input logic [1:0] busy_v, input int delay, input string tag);
        logic       w, exp_err;
        logic [3:0] op;
        logic [7:0] a, b, exp_data;
        logic [1:0] exp_ready;
        w         = (v == 2'b11) ? ~m_last : v[1];
        op        = w ? op1 : op0;
        a         = w ? a1 : a0;
        b         = w ? b1 : b0;
        exp_err   = OPCHECK && (op == 4'hD || op == 4'hE);
        exp_data  = exp_err ? 8'h00 : alu_ref(op, a, b);
        exp_ready = w ? 2'b10 : 2'b01;

        req_valid = v;
        req0_op = op0; req0_a = a0; req0_b = b0;
        req1_op = op1; req1_a = a1; req1_b = b1;
        #1;
        checks++;
        if ({req_ready, busy} !== {exp_ready, 1'b0}) begin
            failures++;
            $display("FAIL %s grant: ready/busy=%b/%b exp %b/0", tag, req_ready, busy, exp_ready);
        end
        @(posedge clk); #1;
        m_last = w;
        if (!exp_err) begin
            m_sel = op; m_a = a; m_b = b;
        end
        req_valid = busy_v;
        req0_op = 4'($urandom); req0_a = 8'($urandom); req0_b = 8'($urandom);
        req1_op = 4'($urandom); req1_a = 8'($urandom); req1_b = 8'($urandom);
        rsp_ready = (delay == 0);
        #1;
        checks++;
        if ({req_ready, busy, alu_sel, alu_a, alu_b} !== {2'b00, 1'b1, m_sel, m_a, m_b}) begin
            failures++;
            $display("FAIL %s issue: ready=%b busy=%b sel/a/b=%h/%h/%h exp 00 1 %h/%h/%h",
                     tag, req_ready, busy, alu_sel, alu_a, alu_b, m_sel, m_a, m_b);
        end
        if (!exp_err) begin
            checks++;
            if (rsp_valid !== 1'b0) begin
                failures++;
                $display("FAIL %s early_rsp: rsp_valid=%b exp 0", tag, rsp_valid);
            end
            @(posedge clk); #1;
        end
        for (int k = 0; k <= delay; k++) begin
            rsp_ready = (k == delay);
            #1;
            checks++;
            if ({rsp_valid, rsp_id, rsp_err, rsp_data, req_ready, busy, op_count} !==
                {1'b1, w, exp_err, exp_data, 2'b00, 1'b1, m_count}) begin
                failures++;
                $display("FAIL %s rsp[%0d]: v/id/err/data=%b/%b/%b/%h ready=%b busy=%b cnt=%0d exp 1/%b/%b/%h 00 1 %0d",
                         tag, k, rsp_valid, rsp_id, rsp_err, rsp_data, req_ready, busy, op_count,
                         w, exp_err, exp_data, m_count);
            end
            @(posedge clk); #1;
        end
        m_count   = m_count + 16'd1;
        req_valid = 2'b00;
        rsp_ready = 1'b0;
        #1;
        checks++;
        if ({rsp_valid, rsp_err, busy, op_count} !== {1'b0, 1'b0, 1'b0, m_count}) begin
            failures++;
            $display("FAIL %s done: v/err/busy=%b/%b/%b cnt=%0d exp 0/0/0 %0d",
                     tag, rsp_valid, rsp_err, busy, op_count, m_count);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; req_valid = 2'b00; rsp_ready = 1'b0;
        req0_op = '0; req0_a = '0; req0_b = '0;
        req1_op = '0; req1_a = '0; req1_b = '0;
        model_reset();
        repeat (2) @(negedge clk);
        checks++;
        if ({req_ready, alu_sel, alu_a, alu_b, rsp_valid, rsp_id, rsp_data, rsp_err, busy, op_count} !== '0) begin
            failures++;
            $display("FAIL reset_values: sel=%h a=%h b=%h v=%b id=%b data=%h err=%b busy=%b cnt=%0d ready=%b exp all 0",
                     alu_sel, alu_a, alu_b, rsp_valid, rsp_id, rsp_data, rsp_err, busy, op_count, req_ready);
        end
        rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_drop();
        req_valid = 2'b11;
        #1;
        checks++;
        if (req_ready !== 2'b01) begin
            failures++;
            $display("FAIL first_tie: ready=%b exp 01", req_ready);
        end
        req_valid = 2'b00;
        @(posedge clk); #1;
        checks++;
        if ({busy, rsp_valid, alu_sel} !== {1'b0, 1'b0, 4'h0}) begin
            failures++;
            $display("FAIL drop_no_effect: busy=%b v=%b sel=%h exp 0/0/0", busy, rsp_valid, alu_sel);
        end
    endtask

    task automatic test_reset_mid();
        req_valid = 2'b01; req0_op = 4'h1; req0_a = 8'h5A; req0_b = 8'h00;
        @(posedge clk); #1;
        req_valid = 2'b00;
        checks++;
        if ({busy, alu_sel, alu_a} !== {1'b1, 4'h1, 8'h5A}) begin
            failures++;
            $display("FAIL mid_exec: busy=%b sel=%h a=%h exp 1/1/5a", busy, alu_sel, alu_a);
        end
        rst_n = 1'b0;
        #1;
        checks++;
        if ({rsp_valid, alu_sel, alu_a, busy, op_count} !== '0) begin
            failures++;
            $display("FAIL reset_abort: v=%b sel=%h a=%h busy=%b cnt=%0d exp all 0",
                     rsp_valid, alu_sel, alu_a, busy, op_count);
        end
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        run_txn(2'b01, 4'h1, 8'h5A, 8'h00, 4'h0, 8'h00, 8'h00, 2'b00, 0, "retry");
    endtask

    task automatic test_single();
        run_txn(2'b01, 4'h1, 8'h5A, 8'h00, 4'h3, 8'h11, 8'h22, 2'b00, 0, "single");
        checks++;
        if (rsp_data !== 8'h5A) begin
            failures++;
            $display("FAIL single_data_hold: rsp_data=%h exp 5a", rsp_data);
        end
    endtask

    task automatic test_tie();
        run_txn(2'b11, 4'h9, 8'h0F, 8'h00, 4'h5, 8'hFF, 8'h3C, 2'b11, 0, "tie1");
        run_txn(2'b11, 4'h9, 8'h0F, 8'h00, 4'h5, 8'hFF, 8'h3C, 2'b11, 0, "tie2");
        run_txn(2'b11, 4'hC, 8'h10, 8'h20, 4'hB, 8'h30, 8'h01, 2'b00, 1, "tie3");
    endtask

    task automatic test_backpressure();
        run_txn(2'b10, 4'h2, 8'h00, 8'h00, 4'hF, 8'h12, 8'h34, 2'b01, 4, "backpressure");
    endtask

    task automatic test_illegal();
        run_txn(2'b01, 4'hE, 8'hAA, 8'h55, 4'h0, 8'h00, 8'h00, 2'b00, 0, "illegal_e");
        run_txn(2'b10, 4'h0, 8'h00, 8'h00, 4'hD, 8'h01, 8'h02, 2'b10, 2, "illegal_d");
    endtask

    task automatic test_wrap();
        force dut.op_count = 16'hFFFF;
        #1;
        release dut.op_count;
        m_count = 16'hFFFF;
        #1;
        checks++;
        if (op_count !== 16'hFFFF) begin
            failures++;
            $display("FAIL wrap_preload: cnt=%0d exp 65535", op_count);
        end
        run_txn(2'b01, 4'hA, 8'hFF, 8'h00, 4'h0, 8'h00, 8'h00, 2'b00, 0, "wrap");
        checks++;
        if (op_count !== 16'h0000) begin
            failures++;
            $display("FAIL wrap_zero: cnt=%0d exp 0", op_count);
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 40; i++) begin
            run_txn(2'($urandom_range(1, 3)),
                    4'($urandom), 8'($urandom), 8'($urandom),
                    4'($urandom), 8'($urandom), 8'($urandom),
                    2'($urandom), $urandom_range(0, 3), "random");
            if ($urandom_range(0, 3) == 0) begin
                @(posedge clk); #1;
                checks++;
                if ({busy, rsp_valid, req_ready} !== 4'b0000) begin
                    failures++;
                    $display("FAIL random_gap: busy=%b v=%b ready=%b exp 0 0 00", busy, rsp_valid, req_ready);
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_drop();
        test_reset_mid();
        test_single();
        test_tie();
        test_backpressure();
        test_illegal();
        test_random();
        test_wrap();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog expired");
    end

endmodule
